full_adder32_cla: RTL and testbench
===================================

Name: full_adder32_cla

Overview:
- 32-bit binary adder with carry-in; produces a 32-bit sum and a carry-out.
- Primary outputs are purely combinational (zero latency), so the block can replace a ripple adder in any datapath.
- A registered copy of the result is also provided for timing-closed consumers.
- Internally built from carry-lookahead groups so the post-route netlist meets timing without relying on tool inference.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of GROUP.
- GROUP, 4, bits per carry-lookahead group.

Ports:
- clk  input  1  single clock; clocks the registered outputs only.
- rst  input  1  asynchronous, active-high reset; clears registered outputs.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  combinational result, low WIDTH bits of a+b+cin.
- cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- sum_q  output  WIDTH  sum registered on rising clk.
- cout_q  output  1  cout registered on rising clk.

Behaviour:
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits, unsigned; no saturation.
- sum/cout are combinational, with no dependence on clk or rst. They are valid whenever the inputs are stable, including during reset.
- sum_q/cout_q capture sum/cout on every rising clk edge; latency is 1 cycle; there is no enable and no handshake.
- rst asserted (async, any time): sum_q=0, cout_q=0 immediately. They hold 0 while rst=1.
- First capture happens on the first rising edge after rst deasserts.
- Carry structure: per group, generate g_i=a_i&b_i and propagate p_i=a_i^b_i.
  - Group carry c_{i+1}=g_i|(p_i&c_i) is flattened to two-level lookahead.
  - Group generate and propagate feed a second-level lookahead across the WIDTH/GROUP groups.
  - sum_i=p_i^c_i; cout equals the final group carry.
- Boundaries:
  - All-ones plus cin=1 wraps: sum=0, cout=1.
  - Zero inputs give sum=0, cout=0.
  - X on any input propagates to the outputs; no X-masking.
- Outputs must be bit-identical to the behavioural expression a+b+cin for all 2^65 input combinations.

Optional Feature:
- Macro FA32_OVERFLOW_EN.
- Defined: adds output ovf (1) and ovf_q (1).
  - ovf = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - ovf_q is registered like cout_q and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is unchanged.

Decomposition:
- Package full_adder32_pkg: localparams WIDTH_DEFAULT=32, GROUP_DEFAULT=4, NUM_GROUPS=WIDTH/GROUP.
  - Typedef word_t (logic [WIDTH-1:0]).
  - Function ref_add(a,b,cin), returning the WIDTH+1-bit reference result, for use by verification.
- Sub-module cla_group: GROUP-bit lookahead cell.
  - Inputs: a, b, cin.
  - Outputs: sum, group generate G, group propagate P.
  - Instantiated NUM_GROUPS times under a generate loop.
- The top level holds the second-level lookahead, the output registers and the optional overflow logic.

Test Plan:
- Reset/zero: rst=1 then a=0, b=0, cin=0.
  - Expect sum=0, cout=0; sum_q=0, cout_q=0 held during reset.
  - One clk after release, sum_q=0.
- Full wrap: a=32'hFFFF_FFFF, b=0, cin=1.
  - Expect sum=0, cout=1 combinationally; sum_q=0, cout_q=1 after one rising edge.
- Group-boundary carry chain: a=32'h0FFF_FFFF, b=32'h0000_0001, cin=0.
  - Expect sum=32'h1000_0000, cout=0.
  - With FA32_OVERFLOW_EN: a=32'h7FFF_FFFF, b=1 gives ovf=1.
- Max operands: a=b=32'hFFFF_FFFF, cin=1.
  - Expect sum=32'hFFFF_FFFF, cout=1.
- Random regression: 1000 cycles of random a, b, cin applied on the negedge.
  - sum/cout compared with !== against ref_add each cycle.
  - sum_q/cout_q compared against the previous cycle's reference; zero mismatches required.
- Async reset mid-operation: rst pulsed between clock edges while a=32'h1234_5678, b=32'h1111_1111.
  - sum_q/cout_q go to 0 without waiting for a clock edge.
  - sum stays 32'h2345_6789 throughout.

Source files
------------

// File: rtl/full_adder32_cla_pkg.sv
// Purpose : shared types, default sizes and the behavioural reference adder for full_adder32_cla.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: WIDTH_DEFAULT, GROUP_DEFAULT, NUM_GROUPS, word_t, ref_add().
package full_adder32_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int GROUP_DEFAULT = 4;
  localparam int NUM_GROUPS    = WIDTH_DEFAULT / GROUP_DEFAULT;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  // Plain a+b+cin at WIDTH+1 bits; the golden value the lookahead tree must match.
  function automatic logic [WIDTH_DEFAULT:0] ref_add(input word_t a, input word_t b, input logic cin);
    logic [WIDTH_DEFAULT:0] cin_ext;
    cin_ext = {{WIDTH_DEFAULT{1'b0}}, cin};
    return {1'b0, a} + {1'b0, b} + cin_ext;
  endfunction

endpackage

// File: rtl/full_adder32_cla_group.sv
// Purpose : GROUP-bit carry-lookahead cell; local sum plus group generate/propagate.
// Latency : combinational.
// Backpressure: none (pure datapath).
// Ports   : a, b (GROUP bits), cin -> sum (GROUP bits), g (group generate), p (group propagate).
module cla_group
  import full_adder32_pkg::*;
#(
  parameter int GROUP = GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each internal carry is written as a flat sum of products:
  //   c_i = g_{i-1} | p_{i-1}g_{i-2} | ... | p_{i-1}..p_0 cin
  // so no carry is built from another carry (no ripple).
  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < GROUP; i++) begin
      acc = cin;
      for (int k = 0; k < i; k++) acc = acc & prop[k];
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) term = term & prop[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  // Kept apart from the carry block: g/p never depend on cin, which keeps the
  // second-level lookahead in the parent free of false combinational loops.
  always_comb begin
    logic term;
    g    = 1'b0;
    term = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = gen[j];
      for (int k = j + 1; k < GROUP; k++) term = term & prop[k];
      g = g | term;
    end
  end

  assign p   = &prop;
  assign sum = prop ^ c;

endmodule

// File: rtl/full_adder32_cla.sv
// Purpose : WIDTH-bit two-level carry-lookahead adder, combinational result plus registered copy.
// Latency : sum/cout combinational; sum_q/cout_q 1 cycle after the inputs.
// Backpressure: none; registers capture every rising clk, no enable or handshake.
// Ports   : clk, rst (async active-high, clears registered outputs only), a, b, cin,
//           sum, cout (combinational), sum_q, cout_q (registered).
// Option  : FA32_OVERFLOW_EN adds ovf (signed overflow) and ovf_q (its registered copy).
// WIDTH must be a multiple of GROUP.
module full_adder32_cla
  import full_adder32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int GROUP = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef FA32_OVERFLOW_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  localparam int NG = WIDTH / GROUP;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   gc;     // gc[k] = carry into group k, gc[NG] = carry out

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (a[k*GROUP +: GROUP]),
      .b   (b[k*GROUP +: GROUP]),
      .cin (gc[k]),
      .sum (sum[k*GROUP +: GROUP]),
      .g   (grp_g[k]),
      .p   (grp_p[k])
    );
  end

  // Second level: same flat sum-of-products form, over group G/P instead of bit g/p.
  always_comb begin
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    gc    = '0;
    gc[0] = cin;
    for (int i = 1; i <= NG; i++) begin
      acc = cin;
      for (int k = 0; k < i; k++) acc = acc & grp_p[k];
      for (int j = 0; j < i; j++) begin
        term = grp_g[j];
        for (int k = j + 1; k < i; k++) term = term & grp_p[k];
        acc = acc | term;
      end
      gc[i] = acc;
    end
  end

  assign cout = gc[NG];

`ifdef FA32_OVERFLOW_EN
  logic c_msb;
  // Carry into the MSB recovered from its sum bit: sum = a ^ b ^ c.
  assign c_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
  assign ovf   = c_msb ^ cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_full_adder32_cla.sv
// Purpose : scoreboard bench for full_adder32_cla (directed corners, random run, async reset).
// Latency : checks combinational outputs #1 after negedge drive, registered outputs #1 after posedge.
// Backpressure: n/a.
module tb_full_adder32_cla;
  import full_adder32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        cin = 1'b0;
  logic [31:0] sum, sum_q;
  logic        cout, cout_q;
`ifdef FA32_OVERFLOW_EN
  logic        ovf, ovf_q;
  logic        oq[$];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] sb[$];

  full_adder32_cla dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef FA32_OVERFLOW_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive at negedge, check combinational result, queue it, then check the
  // registered copy after the following rising edge.
  task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic vc, input string tag);
    logic [32:0] e;
    logic [32:0] got_q;
    @(negedge clk);
    a = va; b = vb; cin = vc;
    e = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
    #1;
    chk({tag, "_comb"}, {31'd0, cout, sum}, {31'd0, e});
    sb.push_back(e);
`ifdef FA32_OVERFLOW_EN
    begin
      logic eo;
      eo = (va[31] == vb[31]) && (e[31] != va[31]);
      chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      oq.push_back(eo);
    end
`endif
    @(posedge clk);
    #1;
    chk({tag, "_sbdepth"}, 64'(sb.size()), 64'd1);
    got_q = {cout_q, sum_q};
    if (sb.size() > 0) chk({tag, "_reg"}, {31'd0, got_q}, {31'd0, sb.pop_front()});
`ifdef FA32_OVERFLOW_EN
    if (oq.size() > 0) chk({tag, "_ovfq"}, {63'd0, ovf_q}, {63'd0, oq.pop_front()});
`endif
  endtask

  initial begin
    // Reset with zero inputs: registered outputs held low across an edge.
    #2;
    chk("rst_comb", {31'd0, cout, sum}, 64'd0);
    chk("rst_reg0", {31'd0, cout_q, sum_q}, 64'd0);
    @(posedge clk); #1;
    chk("rst_hold", {31'd0, cout_q, sum_q}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_first", {31'd0, cout_q, sum_q}, 64'd0);

    // Reference function sanity against hand-derived constants.
    chk("ref_wrap", {31'd0, ref_add(32'hFFFF_FFFF, 32'h0, 1'b1)}, {31'd0, 33'h1_0000_0000});

    // Directed corners.
    step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "wrap");
    chk("wrap_const", {31'd0, cout_q, sum_q}, {31'd0, 33'h1_0000_0000});
    step(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, "grpchain");
    chk("grpchain_const", {31'd0, cout, sum}, {31'd0, 33'h0_1000_0000});
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "sovf");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "maxop");
    chk("maxop_const", {31'd0, cout, sum}, {31'd0, 33'h1_FFFF_FFFF});
    step(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
    step(32'h8000_0000, 32'h8000_0000, 1'b0, "negovf");
    step(32'h0000_000F, 32'h0000_0001, 1'b0, "grp0out");

    // Random regression.
    for (int i = 0; i < 1000; i++)
      step($urandom, $urandom, 1'($urandom_range(0, 1)), "rand");

    // Async reset between edges.
    step(32'h1234_5678, 32'h1111_1111, 1'b0, "pre_arst");
    #3;
    rst = 1'b1;
    #1;
    chk("arst_regclr", {31'd0, cout_q, sum_q}, 64'd0);
    chk("arst_sum", {32'd0, sum}, {32'd0, 32'h2345_6789});
`ifdef FA32_OVERFLOW_EN
    chk("arst_ovfq", {63'd0, ovf_q}, 64'd0);
`endif
    @(posedge clk); #1;
    chk("arst_hold", {31'd0, cout_q, sum_q}, 64'd0);
    chk("arst_sum2", {31'd0, cout, sum}, {31'd0, 33'h0_2345_6789});
    @(negedge clk);
    rst = 1'b0;
    step(32'h1234_5678, 32'h1111_1111, 1'b0, "post_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
